// File: rtl/fetch_stage1_tagged_cache.sv
// Direct-mapped, tagged L1 instruction cache with a single-request refill FSM.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module fetch_stage1_tagged_cache #(
    parameter int unsigned BLOCK_BYTES = 32,
    parameter int unsigned LINES       = 64,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       fetchValid_i,
    input  logic [ADDR_W-1:0]          blockAddr_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    output logic                       ready_o,
    output logic [BLOCK_BYTES*8-1:0]   block_o,
    output logic                       enable_o,
    output logic                       refillReq_o,
    output logic [ADDR_W-1:0]          refillAddr_o,
    input  logic                       refillValid_i,
    input  logic [BLOCK_BYTES*8-1:0]   refillBlock_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                hitCount_o,
    output logic [31:0]                missCount_o
`endif
);

    localparam int unsigned DW    = BLOCK_BYTES * 8;
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_MISS = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [DW-1:0]     block_q, block_d;
    logic              enable_q, enable_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DW-1:0]     data_q [LINES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  rf_idx;
    logic              lk_hit;
    logic              line_we;
    logic              acc_hit;
    logic              acc_miss;

    assign lk_idx  = blockAddr_i[IDX_W-1:0];
    assign lk_tag  = blockAddr_i[ADDR_W-1:IDX_W];
    assign rf_idx  = raddr_q[IDX_W-1:0];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign ready_o = (state_q == ST_RUN) && !stall_i;

    assign block_o      = block_q;
    assign enable_o     = enable_q;
    assign refillReq_o  = req_q;
    assign refillAddr_o = raddr_q;

    // Next-state: lookup in RUN, wait for the refill ack in MISS; flush overrides valid bits last.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        block_d  = block_q;
        enable_d = enable_q;
        req_d    = req_q;
        raddr_d  = raddr_q;
        line_we  = 1'b0;
        acc_hit  = 1'b0;
        acc_miss = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!stall_i) begin
                    if (fetchValid_i && lk_hit) begin
                        acc_hit  = 1'b1;
                        block_d  = data_q[lk_idx];
                        enable_d = 1'b1;
                    end else if (fetchValid_i) begin
                        acc_miss = 1'b1;
                        enable_d = 1'b0;
                        req_d    = 1'b1;
                        raddr_d  = blockAddr_i;
                        state_d  = ST_MISS;
                    end else begin
                        enable_d = 1'b0;
                    end
                end
            end
            default: begin
                enable_d = 1'b0;
                if (refillValid_i) begin
                    line_we         = 1'b1;
                    valid_d[rf_idx] = 1'b1;
                    req_d           = 1'b0;
                    state_d         = ST_RUN;
                end
            end
        endcase
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_RUN;
            valid_q  <= '0;
            block_q  <= '0;
            enable_q <= 1'b0;
            req_q    <= 1'b0;
            raddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            block_q  <= block_d;
            enable_q <= enable_d;
            req_q    <= req_d;
            raddr_q  <= raddr_d;
        end
    end

    // Tag/data arrays are never cleared; valid bits alone gate hits.
    always_ff @(posedge clock_i) begin
        if (line_we && !reset_i) begin
            tag_q[rf_idx]  <= raddr_q[ADDR_W-1:IDX_W];
            data_q[rf_idx] <= refillBlock_i;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (acc_hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (acc_miss) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCount_o  = hit_cnt_q;
    assign missCount_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage1_tagged_cache.sv
// Bench for fetch_stage1_tagged_cache: directed fetch/refill/flush/stall/reset scenarios,
// an address-keyed cache model checked every negedge, plus literal spot checks.
module tb_fetch_stage1_tagged_cache;

    localparam int unsigned BLOCK_BYTES = 32;
    localparam int unsigned LINES       = 64;
    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned DW          = BLOCK_BYTES * 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_valid = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              ready;
    logic [DW-1:0]     blk;
    logic              en;
    logic              req;
    logic [ADDR_W-1:0] raddr;
    logic              rvalid = 1'b0;
    logic [DW-1:0]     rblock = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_stage1_tagged_cache #(
        .BLOCK_BYTES(BLOCK_BYTES), .LINES(LINES), .ADDR_W(ADDR_W)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .fetchValid_i  (fetch_valid),
        .blockAddr_i   (fetch_addr),
        .stall_i       (stall),
        .flush_i       (flush),
        .ready_o       (ready),
        .block_o       (blk),
        .enable_o      (en),
        .refillReq_o   (req),
        .refillAddr_o  (raddr),
        .refillValid_i (rvalid),
        .refillBlock_i (rblock)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hitCount_o    (hit_cnt),
        .missCount_o   (miss_cnt)
`endif
    );

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Model: each line remembers the full block address it holds, so a hit is an address match.
    bit                m_valid [int];
    logic [ADDR_W-1:0] m_addr  [int];
    logic [DW-1:0]     m_data  [int];
    bit                m_busy = 1'b0;
    bit                m_ok   = 1'b0;
    logic [DW-1:0]     e_blk  = '0;
    logic              e_en   = 1'b0;
    logic              e_req  = 1'b0;
    logic [ADDR_W-1:0] e_raddr = '0;
    int unsigned       m_hits = 0;
    int unsigned       m_misses = 0;

    always @(posedge clk) begin
        int li;
        if (rst) begin
            m_valid.delete();
            m_busy = 1'b0; m_ok = 1'b1;
            e_blk = '0; e_en = 1'b0; e_req = 1'b0; e_raddr = '0;
            m_hits = 0; m_misses = 0;
        end else begin
            if (!m_busy) begin
                if (!stall && fetch_valid) begin
                    li = int'(fetch_addr) % LINES;
                    if (m_valid.exists(li) && m_addr[li] == fetch_addr) begin
                        e_blk = m_data[li]; e_en = 1'b1; m_hits++;
                    end else begin
                        e_en = 1'b0; e_req = 1'b1; e_raddr = fetch_addr; m_busy = 1'b1; m_misses++;
                    end
                end else if (!stall) begin
                    e_en = 1'b0;
                end
            end else if (rvalid) begin
                li = int'(e_raddr) % LINES;
                m_valid[li] = 1'b1; m_addr[li] = e_raddr; m_data[li] = rblock;
                e_req = 1'b0; m_busy = 1'b0;
            end
            if (flush) m_valid.delete();
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("ready_o", DW'(ready), DW'(!m_busy && !stall));
            chk("enable_o", DW'(en), DW'(e_en));
            chk("block_o", blk, e_blk);
            chk("refillReq_o", DW'(req), DW'(e_req));
            chk("refillAddr_o", DW'(raddr), DW'(e_raddr));
`ifdef ICACHE_PERF_CNT_EN
            chk("hitCount_o", DW'(hit_cnt), DW'(m_hits));
            chk("missCount_o", DW'(miss_cnt), DW'(m_misses));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        fetch_valid = 1'b1; fetch_addr = a;
        cyc(1);
        fetch_valid = 1'b0;
    endtask

    task automatic ack(input logic [DW-1:0] d);
        rvalid = 1'b1; rblock = d;
        cyc(1);
        rvalid = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] k);
        return {8{k}};
    endfunction

    initial begin
        // 1: cold miss, delayed ack, re-issue hits
        cyc(1);
        rst = 1'b0;
        chk("rst_enable", DW'(en), DW'(1'b0));
        chk("rst_req", DW'(req), DW'(1'b0));
        chk("rst_block", blk, '0);
        fetch(11'h005);
        chk("t1_req", DW'(req), DW'(1'b1));
        chk("t1_raddr", DW'(raddr), DW'(11'h005));
        cyc(2);
        ack(pat(32'hAAAA_0005));
        chk("t1_req_drop", DW'(req), DW'(1'b0));
        fetch(11'h005);
        chk("t1_hit_en", DW'(en), DW'(1'b1));
        chk("t1_hit_blk", blk, pat(32'hAAAA_0005));
`ifdef ICACHE_PERF_CNT_EN
        chk("t1_hits", DW'(hit_cnt), DW'(32'd1));
        chk("t1_misses", DW'(miss_cnt), DW'(32'd1));
`endif
        // 2: conflict eviction on index 5
        fetch(11'h045);
        chk("t2_raddr", DW'(raddr), DW'(11'h045));
        ack(pat(32'hBBBB_0045));
        fetch(11'h045);
        chk("t2_hit_blk", blk, pat(32'hBBBB_0045));
        fetch(11'h005);
        chk("t2_evicted", DW'(req), DW'(1'b1));
        ack(pat(32'hAAAA_0005));
        // 3/4: prefill 1..3, then hit stream with a 2-cycle stall
        for (int k = 1; k <= 3; k++) begin
            fetch(ADDR_W'(k));
            ack(pat(32'hC0DE_0000 | k));
        end
        fetch_valid = 1'b1; fetch_addr = 11'h001; cyc(1);
        chk("t3_blk1", blk, pat(32'hC0DE_0001));
        fetch_addr = 11'h002; cyc(1);
        chk("t3_blk2", blk, pat(32'hC0DE_0002));
        chk("t3_en2", DW'(en), DW'(1'b1));
        fetch_addr = 11'h003; stall = 1'b1; cyc(2);
        chk("t4_frozen", blk, pat(32'hC0DE_0002));
        chk("t4_ready", DW'(ready), DW'(1'b0));
        stall = 1'b0; cyc(1);
        fetch_valid = 1'b0;
        chk("t4_resume", blk, pat(32'hC0DE_0003));
        // 5: flush racing the refill ack, and flush racing a hit
        fetch(11'h007);
        flush = 1'b1; ack(pat(32'hEEEE_0007)); flush = 1'b0;
        fetch(11'h007);
        chk("t5_flush_ack_miss", DW'(req), DW'(1'b1));
        ack(pat(32'hEEEE_0007));
        fetch(11'h008);
        ack(pat(32'h8888_0008));
        flush = 1'b1; fetch(11'h008); flush = 1'b0;
        chk("t5_hit_with_flush", blk, pat(32'h8888_0008));
        fetch(11'h008);
        chk("t5_post_flush_miss", DW'(req), DW'(1'b1));
        ack(pat(32'h8888_0008));
        // 6: reset during MISS, then ack in RUN is ignored
        fetch(11'h00A);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("t6_req_dropped", DW'(req), DW'(1'b0));
        chk("t6_en", DW'(en), DW'(1'b0));
`ifdef ICACHE_PERF_CNT_EN
        chk("t6_cnt_clr", DW'(hit_cnt | miss_cnt), DW'(32'd0));
`endif
        ack(pat(32'hDEAD_000B));
        fetch(11'h00B);
        chk("t6_stray_ack_ignored", DW'(req), DW'(1'b1));
        ack(pat(32'h1234_000B));
        fetch(11'h00B);
        chk("t6_hit_blk", blk, pat(32'h1234_000B));
        cyc(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
